// File: rtl/dsp_wdata_channel.sv
// ---------------------------------------------------------------------------
// dsp_wdata_channel
//
// Write-data dispatcher on the slave-interface side of the interconnect.
// Master W beats are buffered in a FIFO; each burst is steered to the slave
// selected by the AW dispatcher. When the WLAST beat is accepted by the
// slave, a one-cycle pulse tells the AW dispatcher to pop its routing entry.
//
// Ports:
//   ACLK_i              clock
//   ARESET_i            synchronous, active-high reset
//   m_W*_i / m_WREADY_o master W channel (data, strobes, last, valid/ready)
//   sa_W*_o             per-slave W channel, flattened with slave 0 in LSBs;
//                       data/strb/last are broadcast, only WVALID is steered
//   sa_WREADY_i         per-slave ready
//   dsp_AW_slv_id_i     target slave of the oldest pending AW
//   dsp_AW_disable_i    high when no AW route is pending
//   dsp_AW_shift_en_o   pulse: pop the AW routing entry
//
// Optional feature (macro DSP_WDATA_LEN_CHECK_EN):
//   dsp_AW_len_i        AWLEN of the routed burst, sampled on IDLE->BURST
//   wlast_err_o         sticky flag: WLAST position disagrees with AWLEN
// ---------------------------------------------------------------------------
module dsp_wdata_channel #(
    parameter int unsigned SLV_AMT         = 2,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned SLV_ID_W        = (SLV_AMT > 1) ? $clog2(SLV_AMT) : 1,
    parameter int unsigned DSP_WDATA_DEPTH = 16
) (
    input  logic                               ACLK_i,
    input  logic                               ARESET_i,
    input  logic [DATA_WIDTH-1:0]              m_WDATA_i,
    input  logic [DATA_WIDTH/8-1:0]            m_WSTRB_i,
    input  logic                               m_WLAST_i,
    input  logic                               m_WVALID_i,
    output logic                               m_WREADY_o,
    output logic [DATA_WIDTH*SLV_AMT-1:0]      sa_WDATA_o,
    output logic [(DATA_WIDTH/8)*SLV_AMT-1:0]  sa_WSTRB_o,
    output logic [SLV_AMT-1:0]                 sa_WLAST_o,
    output logic [SLV_AMT-1:0]                 sa_WVALID_o,
    input  logic [SLV_AMT-1:0]                 sa_WREADY_i,
    input  logic [SLV_ID_W-1:0]                dsp_AW_slv_id_i,
    input  logic                               dsp_AW_disable_i,
    output logic                               dsp_AW_shift_en_o
`ifdef DSP_WDATA_LEN_CHECK_EN
    ,
    input  logic [7:0]                         dsp_AW_len_i,
    output logic                               wlast_err_o
`endif
);

    localparam int unsigned StrbW  = DATA_WIDTH / 8;
    localparam int unsigned PtrW   = $clog2(DSP_WDATA_DEPTH);
    localparam int unsigned EntryW = DATA_WIDTH + StrbW + 1;

    typedef enum logic {
        StIdle,
        StBurst
    } state_e;

    logic [EntryW-1:0]     mem [DSP_WDATA_DEPTH];
    logic [PtrW:0]         wr_ptr;
    logic [PtrW:0]         rd_ptr;
    state_e                state;
    logic [SLV_ID_W-1:0]   cur_slv;

    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  pop;
    logic [EntryW-1:0]     head;
    logic [DATA_WIDTH-1:0] head_data;
    logic [StrbW-1:0]      head_strb;
    logic                  head_last;

    // FIFO status: pointers carry a wrap bit above the index bits.
    assign full  = (wr_ptr[PtrW] != rd_ptr[PtrW]) &&
                   (wr_ptr[PtrW-1:0] == rd_ptr[PtrW-1:0]);
    assign empty = (wr_ptr == rd_ptr);

    // Ready depends only on FIFO state and reset, never on slave readiness.
    assign m_WREADY_o = ~full & ~ARESET_i;
    assign push       = m_WVALID_i & m_WREADY_o;

    assign head      = mem[rd_ptr[PtrW-1:0]];
    assign head_data = head[EntryW-1 -: DATA_WIDTH];
    assign head_strb = head[StrbW:1];
    assign head_last = head[0];

    assign sa_WDATA_o = {SLV_AMT{head_data}};
    assign sa_WSTRB_o = {SLV_AMT{head_strb}};
    assign sa_WLAST_o = {SLV_AMT{head_last}};

    // Steer valid to the latched slave only; an out-of-range index matches no
    // slot, so nothing is offered and the FIFO stalls.
    always_comb begin
        sa_WVALID_o = '0;
        pop         = 1'b0;
        for (int i = 0; i < int'(SLV_AMT); i++) begin
            if (state == StBurst && !empty && cur_slv == SLV_ID_W'(i)) begin
                sa_WVALID_o[i] = 1'b1;
                pop            = sa_WREADY_i[i];
            end
        end
    end

    assign dsp_AW_shift_en_o = pop & head_last;

    always_ff @(posedge ACLK_i) begin
        if (push) begin
            mem[wr_ptr[PtrW-1:0]] <= {m_WDATA_i, m_WSTRB_i, m_WLAST_i};
        end
    end

    always_ff @(posedge ACLK_i) begin
        if (ARESET_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            state   <= StIdle;
            cur_slv <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + (PtrW+1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (PtrW+1)'(1);
            end
            case (state)
                StIdle: begin
                    // Route acceptance does not wait for data in the FIFO.
                    if (!dsp_AW_disable_i) begin
                        cur_slv <= dsp_AW_slv_id_i;
                        state   <= StBurst;
                    end
                end
                StBurst: begin
                    if (dsp_AW_shift_en_o) begin
                        state <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

`ifdef DSP_WDATA_LEN_CHECK_EN
    logic [7:0] beat_cnt;
    logic [7:0] burst_len;

    // beat_cnt holds the number of beats already accepted in this burst, so
    // the WLAST beat must arrive exactly when beat_cnt equals AWLEN.
    always_ff @(posedge ACLK_i) begin
        if (ARESET_i) begin
            beat_cnt    <= '0;
            burst_len   <= '0;
            wlast_err_o <= 1'b0;
        end else begin
            if (state == StIdle && !dsp_AW_disable_i) begin
                burst_len <= dsp_AW_len_i;
                beat_cnt  <= '0;
            end else if (pop) begin
                beat_cnt <= beat_cnt + 8'd1;
                if (head_last != (beat_cnt == burst_len)) begin
                    wlast_err_o <= 1'b1;
                end
            end
        end
    end
`endif

`ifndef SYNTHESIS
    localparam logic [SLV_ID_W:0] SlvAmtW = (SLV_ID_W+1)'(SLV_AMT);

    always @(posedge ACLK_i) begin
        if (!ARESET_i && state == StBurst) begin
            assert ({1'b0, cur_slv} < SlvAmtW)
            else $error("dsp_wdata_channel: routed slave index %0d out of range", cur_slv);
        end
    end
`endif

endmodule

// File: tb/tb_dsp_wdata_channel.sv
`timescale 1ns/1ps
module tb_dsp_wdata_channel;

    localparam int SLV_AMT = 2;
    localparam int DW      = 32;
    localparam int SW      = DW / 8;
    localparam int DEPTH   = 16;

    logic                  clk = 1'b0;
    logic                  areset;
    logic [DW-1:0]         m_wdata;
    logic [SW-1:0]         m_wstrb;
    logic                  m_wlast;
    logic                  m_wvalid;
    logic                  m_wready;
    logic [DW*SLV_AMT-1:0] sa_wdata;
    logic [SW*SLV_AMT-1:0] sa_wstrb;
    logic [SLV_AMT-1:0]    sa_wlast;
    logic [SLV_AMT-1:0]    sa_wvalid;
    logic [SLV_AMT-1:0]    sa_wready;
    logic                  aw_id = 1'b0;
    logic                  aw_disable = 1'b1;
    logic                  shift_en;
`ifdef DSP_WDATA_LEN_CHECK_EN
    logic [7:0]            aw_len;
    logic                  wlast_err;
`endif

    always #5 clk = ~clk;

    dsp_wdata_channel #(
        .SLV_AMT         (SLV_AMT),
        .DATA_WIDTH      (DW),
        .DSP_WDATA_DEPTH (DEPTH)
    ) dut (
        .ACLK_i            (clk),
        .ARESET_i          (areset),
        .m_WDATA_i         (m_wdata),
        .m_WSTRB_i         (m_wstrb),
        .m_WLAST_i         (m_wlast),
        .m_WVALID_i        (m_wvalid),
        .m_WREADY_o        (m_wready),
        .sa_WDATA_o        (sa_wdata),
        .sa_WSTRB_o        (sa_wstrb),
        .sa_WLAST_o        (sa_wlast),
        .sa_WVALID_o       (sa_wvalid),
        .sa_WREADY_i       (sa_wready),
        .dsp_AW_slv_id_i   (aw_id),
        .dsp_AW_disable_i  (aw_disable),
        .dsp_AW_shift_en_o (shift_en)
`ifdef DSP_WDATA_LEN_CHECK_EN
        ,
        .dsp_AW_len_i      (aw_len),
        .wlast_err_o       (wlast_err)
`endif
    );

    typedef struct {
        int          slv;
        logic [31:0] data;
        logic [3:0]  strb;
        logic        last;
    } beat_t;

    beat_t exp_q[$];
    int    route_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    int    shift_cnt = 0;
    int    hs_cnt    = 0;

    logic        prev_stall = 1'b0;
    int          prev_slv   = 0;
    logic [31:0] prev_data  = '0;

    // Slave-side scoreboard plus the AW routing-queue model.
    always @(negedge clk) begin
        int          hs_slv;
        beat_t       e;
        logic [31:0] d;
        logic [3:0]  st;
        logic        l;
        logic        exp_shift;
        if (areset) begin
            prev_stall = 1'b0;
        end else begin
            n_checks++;
            if ($countones(sa_wvalid) > 1) begin
                n_fail++;
                $display("FAIL onehot_valid: sa_WVALID=%b, required at most one bit", sa_wvalid);
            end
            if (prev_stall) begin
                n_checks++;
                if (sa_wvalid[prev_slv] !== 1'b1 || sa_wdata[prev_slv*DW +: DW] !== prev_data) begin
                    n_fail++;
                    $display("FAIL head_stable: slave %0d valid=%b data=%h, required valid=1 data=%h",
                             prev_slv, sa_wvalid[prev_slv], sa_wdata[prev_slv*DW +: DW], prev_data);
                end
            end
            prev_stall = 1'b0;
            hs_slv     = -1;
            for (int s = 0; s < SLV_AMT; s++) begin
                if (sa_wvalid[s]) begin
                    if (sa_wready[s]) begin
                        hs_slv = s;
                    end else begin
                        prev_stall = 1'b1;
                        prev_slv   = s;
                        prev_data  = sa_wdata[s*DW +: DW];
                    end
                end
            end
            exp_shift = 1'b0;
            if (hs_slv >= 0) begin
                hs_cnt++;
                d  = sa_wdata[hs_slv*DW +: DW];
                st = sa_wstrb[hs_slv*SW +: SW];
                l  = sa_wlast[hs_slv];
                exp_shift = l;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL beat_unexpected: slave %0d got data %h, required no beat",
                             hs_slv, d);
                end else begin
                    e = exp_q.pop_front();
                    if (hs_slv != e.slv || d !== e.data || st !== e.strb || l !== e.last) begin
                        n_fail++;
                        $display("FAIL beat: got slv=%0d data=%h strb=%h last=%b, required slv=%0d data=%h strb=%h last=%b",
                                 hs_slv, d, st, l, e.slv, e.data, e.strb, e.last);
                    end
                end
            end
            n_checks++;
            if (shift_en !== exp_shift) begin
                n_fail++;
                $display("FAIL shift_en: got %b, required %b", shift_en, exp_shift);
            end
            if (shift_en === 1'b1) begin
                shift_cnt++;
                if (route_q.size() > 0) route_q.delete(0);
            end
        end
        aw_disable = (route_q.size() == 0);
        aw_id      = (route_q.size() > 0) ? 1'(route_q[0]) : 1'b0;
    end

    task automatic add_route(input int slv);
        route_q.push_back(slv);
    endtask

    task automatic send_beat(input int slv, input logic [31:0] data, input logic last);
        int    waited;
        beat_t b;
        m_wvalid = 1'b1;
        m_wdata  = data;
        m_wstrb  = data[3:0];
        m_wlast  = last;
        waited   = 0;
        @(negedge clk);
        while (m_wready !== 1'b1 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        n_checks++;
        if (m_wready !== 1'b1) begin
            n_fail++;
            $display("FAIL send_timeout: m_WREADY=%b after %0d cycles, required 1", m_wready, waited);
        end else begin
            b.slv  = slv;
            b.data = data;
            b.strb = data[3:0];
            b.last = last;
            exp_q.push_back(b);
        end
        @(posedge clk);
        #1;
        m_wvalid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int t = 0;
        while (exp_q.size() != 0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain: %0d beats outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        areset    = 1'b1;
        m_wvalid  = 1'b0;
        m_wdata   = '0;
        m_wstrb   = '0;
        m_wlast   = 1'b0;
        sa_wready = '1;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        n_checks++;
        if (m_wready !== 1'b0 || sa_wvalid !== '0 || shift_en !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: wready=%b wvalid=%b shift=%b, required 0 00 0",
                     m_wready, sa_wvalid, shift_en);
        end
        @(posedge clk);
        #1;
        areset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (m_wready !== 1'b1 || sa_wvalid !== '0) begin
            n_fail++;
            $display("FAIL reset_release: wready=%b wvalid=%b, required 1 00", m_wready, sa_wvalid);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_burst();
        int base = shift_cnt;
        logic [31:0] dat;
        sa_wready = '1;
        add_route(1);
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            beat_t b;
            dat = 32'hD000_0000 + 32'(i) * 32'h0111_1111;
            m_wvalid = 1'b1;
            m_wdata  = dat;
            m_wstrb  = dat[3:0];
            m_wlast  = (i == 3);
            @(negedge clk);
            n_checks++;
            if (sa_wvalid !== ((i == 0) ? 2'b00 : 2'b10)) begin
                n_fail++;
                $display("FAIL single_visibility beat %0d: sa_WVALID=%b, required %b",
                         i, sa_wvalid, (i == 0) ? 2'b00 : 2'b10);
            end
            n_checks++;
            if (m_wready !== 1'b1) begin
                n_fail++;
                $display("FAIL single_wready beat %0d: got %b, required 1", i, m_wready);
            end
            b.slv = 1; b.data = dat; b.strb = dat[3:0]; b.last = (i == 3);
            exp_q.push_back(b);
            @(posedge clk);
            #1;
        end
        m_wvalid = 1'b0;
        wait_drain("single");
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (shift_cnt - base != 1) begin
            n_fail++;
            $display("FAIL single_shift_count: got %0d, required 1", shift_cnt - base);
        end
    endtask

    task automatic test_fill_no_route();
        bit found = 0;
        sa_wready = '1;
        for (int i = 0; i < DEPTH; i++) begin
            send_beat(0, 32'hF000_0000 + 32'(i * 7 + 3), i == DEPTH - 1);
        end
        @(negedge clk);
        n_checks++;
        if (m_wready !== 1'b0 || sa_wvalid !== '0) begin
            n_fail++;
            $display("FAIL fill_full: wready=%b wvalid=%b, required 0 00", m_wready, sa_wvalid);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (m_wready !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_hold: wready=%b, required 0", m_wready);
        end
        add_route(0);
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            if (sa_wvalid[0] && sa_wready[0]) found = 1;
        end
        n_checks++;
        if (!found || m_wready !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_first_pop: found=%0d wready=%b, required found=1 wready=0",
                     found, m_wready);
        end
        @(negedge clk);
        n_checks++;
        if (m_wready !== 1'b1) begin
            n_fail++;
            $display("FAIL fill_ready_return: wready=%b, required 1", m_wready);
        end
        wait_drain("fill");
    endtask

    task automatic test_back_to_back();
        int base = shift_cnt;
        int t0 = -1;
        int t1 = -1;
        sa_wready = '1;
        add_route(0);
        add_route(1);
        fork
            begin
                send_beat(0, 32'hA0A0_0001, 1'b0);
                send_beat(0, 32'hA0A0_0002, 1'b1);
                send_beat(1, 32'hB1B1_0003, 1'b0);
                send_beat(1, 32'hB1B1_0004, 1'b0);
                send_beat(1, 32'hB1B1_0005, 1'b1);
            end
            begin
                for (int c = 0; c < 100 && t1 < 0; c++) begin
                    @(negedge clk);
                    if (sa_wvalid[0] && sa_wready[0] && sa_wlast[0]) t0 = c;
                    if (sa_wvalid[1]) t1 = c;
                end
            end
        join
        wait_drain("b2b");
        n_checks++;
        if (t0 < 0 || t1 - t0 != 2) begin
            n_fail++;
            $display("FAIL b2b_bubble: wlast cycle %0d, next valid cycle %0d, required gap 2", t0, t1);
        end
        n_checks++;
        if (shift_cnt - base != 2) begin
            n_fail++;
            $display("FAIL b2b_shift_count: got %0d, required 2", shift_cnt - base);
        end
    endtask

    task automatic test_backpressure();
        logic pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        int base = hs_cnt;
        int k = 0;
        sa_wready = '0;
        add_route(0);
        for (int i = 0; i < 4; i++) begin
            send_beat(0, 32'hC0DE_0000 + 32'(i * 5 + 1), i == 3);
        end
        while (exp_q.size() != 0 && k < 30) begin
            sa_wready[0] = (k < 4) ? pat[k] : 1'b1;
            @(posedge clk);
            #1;
            k++;
        end
        sa_wready = '1;
        wait_drain("bp");
        n_checks++;
        if (hs_cnt - base != 4) begin
            n_fail++;
            $display("FAIL bp_handshakes: got %0d, required 4", hs_cnt - base);
        end
    endtask

    task automatic test_reset_mid_burst();
        int   base_hs = hs_cnt;
        int   base_sh;
        logic seen = 1'b0;
        sa_wready = '0;
        add_route(0);
        for (int i = 0; i < 4; i++) begin
            send_beat(0, 32'h5EED_0000 + 32'(i), i == 3);
        end
        sa_wready = '1;
        @(posedge clk);
        @(posedge clk);
        #1;
        sa_wready = '0;
        areset    = 1'b1;
        exp_q.delete();
        route_q.delete();
        base_sh = shift_cnt;
        @(posedge clk);
        #1;
        @(negedge clk);
        n_checks++;
        if (sa_wvalid !== '0 || shift_en !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_outputs: wvalid=%b shift=%b, required 00 0", sa_wvalid, shift_en);
        end
        @(posedge clk);
        #1;
        areset    = 1'b0;
        sa_wready = '1;
        n_checks++;
        if (hs_cnt - base_hs != 2) begin
            n_fail++;
            $display("FAIL rst_mid_consumed: got %0d beats, required 2", hs_cnt - base_hs);
        end
        add_route(1);
        repeat (4) begin
            @(negedge clk);
            if (sa_wvalid !== '0) seen = 1'b1;
        end
        n_checks++;
        if (seen) begin
            n_fail++;
            $display("FAIL rst_mid_fifo_empty: stale beat offered, required none");
        end
        @(posedge clk);
        #1;
        send_beat(1, 32'h0000_AF7E, 1'b1);
        wait_drain("rst_mid");
        n_checks++;
        if (shift_cnt - base_sh != 1) begin
            n_fail++;
            $display("FAIL rst_mid_shift_count: got %0d, required 1", shift_cnt - base_sh);
        end
    endtask

`ifdef DSP_WDATA_LEN_CHECK_EN
    task automatic test_len_check();
        test_reset();
        aw_len = 8'd3;
        n_checks++;
        if (wlast_err !== 1'b0) begin
            n_fail++;
            $display("FAIL len_reset: wlast_err=%b, required 0", wlast_err);
        end
        add_route(0);
        for (int i = 0; i < 4; i++) send_beat(0, 32'h1E10_0000 + 32'(i), i == 3);
        wait_drain("len_ok");
        n_checks++;
        if (wlast_err !== 1'b0) begin
            n_fail++;
            $display("FAIL len_ok: wlast_err=%b, required 0", wlast_err);
        end
        add_route(1);
        for (int i = 0; i < 2; i++) send_beat(1, 32'h1E11_0000 + 32'(i), i == 1);
        wait_drain("len_short");
        n_checks++;
        if (wlast_err !== 1'b1) begin
            n_fail++;
            $display("FAIL len_short: wlast_err=%b, required 1", wlast_err);
        end
        add_route(0);
        for (int i = 0; i < 4; i++) send_beat(0, 32'h1E12_0000 + 32'(i), i == 3);
        wait_drain("len_sticky");
        n_checks++;
        if (wlast_err !== 1'b1) begin
            n_fail++;
            $display("FAIL len_sticky: wlast_err=%b, required 1", wlast_err);
        end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef DSP_WDATA_LEN_CHECK_EN
        aw_len = 8'd0;
`endif
        test_reset();
`ifdef DSP_WDATA_LEN_CHECK_EN
        aw_len = 8'd3;
`endif
        test_single_burst();
        test_fill_no_route();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_burst();
`ifdef DSP_WDATA_LEN_CHECK_EN
        test_len_check();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
